fb_rd_fetch: RTL
================

Name: fb_rd_fetch

Overview:
Read-side prefetcher for the frame buffer, sitting directly downstream of the DDR2 manager's frame-buffer read port. It issues fixed-length read requests (rd_mem_req/rd_mem_addr/rd_xfr_len) that walk linearly through one frame starting at BASE_ADDR. Returned 32-bit words (rd_data/rd_data_valid) are buffered in an internal FIFO. The display/pixel pipeline drains the FIFO; frame_start rewinds the fetcher to BASE_ADDR for the next frame.

Parameters:
FIFO_DEPTH, 512, 32-bit word entries in internal FIFO (power of 2, >= 2*XFR_LEN)
XFR_LEN, 10'h080, transfers (32-bit words) per request; even, nonzero
FRAME_XFRS, 16'd600, requests per frame
BASE_ADDR, 25'h0, DDR2 word address {row,col,bank} of first request in a frame

Ports:
clk0  in  1  clock; all logic on rising edge
rst0_n  in  1  asynchronous active-low reset
enable  in  1  fetch enable; 0 = no new requests issued
frame_start  in  1  single-cycle pulse: flush and rewind to BASE_ADDR
rd_mem_req  out  1  read request to DDR2 manager
rd_mem_addr  out  25  request start address
rd_xfr_len  out  10  request length, constant XFR_LEN
rd_mem_grant  in  1  single-cycle request acceptance
rd_data  in  32  returned read data
rd_data_valid  in  1  rd_data qualifier
pix_rd_en  in  1  FIFO pop
pix_data  out  32  popped word
pix_valid  out  1  pix_data valid pulse
pix_empty  out  1  FIFO empty
fifo_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy
frame_done  out  1  pulse: last word of frame written to FIFO
ovf_err  out  1  sticky: data arrived with FIFO full
unf_err  out  1  sticky: pop while empty

Behaviour:
- Reset: rd_mem_req=0, rd_mem_addr=BASE_ADDR, pix_data=0, pix_valid=0, pix_empty=1, fifo_level=0, frame_done=0, ovf_err=0, unf_err=0, FSM=ST_IDLE, request counter=0. rd_xfr_len is always XFR_LEN.
- FSM states: ST_IDLE, ST_CHECK, ST_REQ, ST_DATA, ST_FLUSH, ST_HOLD.
- ST_IDLE -> ST_CHECK when enable=1.
- ST_CHECK:
  - If flush pending -> ST_FLUSH.
  - Else if enable=0 -> ST_IDLE.
  - Else if request counter == FRAME_XFRS -> ST_HOLD.
  - Else if fifo_level <= FIFO_DEPTH-XFR_LEN -> assert rd_mem_req, go to ST_REQ.
  - Else remain in ST_CHECK.
- ST_REQ: hold rd_mem_req=1 and rd_mem_addr stable until rd_mem_grant=1. In the grant cycle deassert rd_mem_req on the next edge, clear the word counter, and go to ST_DATA. A request is never withdrawn before grant.
- ST_DATA:
  - Each rd_data_valid=1 cycle increments the word counter and pushes rd_data, unless discarding.
  - When the counter reaches XFR_LEN: rd_mem_addr += XFR_LEN*8 (mod 2^25), request counter += 1, go to ST_CHECK.
  - Valid may be gapped; no timeout.
- Address step: each 32-bit transfer = two 16-bit DDR words; one DDR word = 4 address units (two bank LSBs).
- frame_done pulses one cycle after the final push of request FRAME_XFRS-1.
- ST_HOLD: waits for frame_start; no requests.
- frame_start:
  - Any state: sets flush-pending.
  - In ST_REQ/ST_DATA: the current burst completes; words still to arrive are counted but discarded.
  - ST_FLUSH (1 cycle): FIFO pointers and level = 0, pix_empty=1, rd_mem_addr=BASE_ADDR, request counter=0, flush-pending cleared, then ST_CHECK.
  - ST_IDLE/ST_HOLD: go directly to ST_FLUSH.
  - frame_start coincident with grant or the last valid word: the burst still completes normally, then flush.
- FIFO:
  - Synchronous; push and pop in the same cycle keeps the level unchanged.
  - Push with level==FIFO_DEPTH: word dropped, ovf_err<=1.
  - pix_rd_en with pix_empty=1: no pop, unf_err<=1, pix_valid=0, pix_data held.
  - Valid pop: pix_data and pix_valid=1 one cycle after pix_rd_en.
  - Errors clear only on reset.
- enable deasserted mid-burst: current request completes; no further requests issued.

Test Plan:
- FIFO_DEPTH=16, XFR_LEN=4, FRAME_XFRS=3, BASE_ADDR=0, enable=1, grant 2 cycles after req, 4 valids each, no pops -> requests at addr 0x000, 0x020, then stall (level=8, next needs <=12, ok) 0x040; frame_done after 12th word; fifo_level=12; ST_HOLD, no 4th req.
- Same, no pops, FRAME_XFRS=8 -> requests stop after level=16 (4 requests); pop 4 words -> 5th request at 0x080 issued.
- frame_start asserted during 2nd of 4 valid words -> remaining 2 words discarded, fifo_level=0, next request addr 0x000.
- Push and pop same cycle at level 5 -> level stays 5, pix_data = oldest word next cycle.
- Pop while empty -> unf_err=1 sticky, pix_valid=0; mgr returns 5 valids for XFR_LEN=4 at full FIFO -> ovf_err=1.
- Assert rst0_n=0 mid ST_DATA -> all outputs at reset values immediately (async), rd_mem_req=0.

Source files
------------

// File: rtl/fb_rd_fetch.sv
// rtl/fb_rd_fetch.sv - frame-buffer read prefetcher: linear burst requests into a pixel FIFO
// Walks one frame from BASE_ADDR in XFR_LEN-word bursts, gated by free FIFO space.
module fb_rd_fetch #(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter logic [9:0]  XFR_LEN    = 10'h080,
  parameter logic [15:0] FRAME_XFRS = 16'd600,
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk0,
  input  logic          rst0_n,
  input  logic          enable,
  input  logic          frame_start,
  output logic          rd_mem_req,
  output logic [24:0]   rd_mem_addr,
  output logic [9:0]    rd_xfr_len,
  input  logic          rd_mem_grant,
  input  logic [31:0]   rd_data,
  input  logic          rd_data_valid,
  input  logic          pix_rd_en,
  output logic [31:0]   pix_data,
  output logic          pix_valid,
  output logic          pix_empty,
  output logic [LW-1:0] fifo_level,
  output logic          frame_done,
  output logic          ovf_err,
  output logic          unf_err
);

  localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] REQ_THRESH = LW'(FIFO_DEPTH - 32'(XFR_LEN));
  // Each 32-bit transfer is two 16-bit DDR words, each spanning 4 address units.
  localparam logic [24:0]   ADDR_STEP  = {12'd0, XFR_LEN, 3'b000};

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_REQ, ST_DATA, ST_FLUSH, ST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [24:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [15:0]   req_cnt_q, req_cnt_d;
  logic [9:0]    word_cnt_q, word_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          frame_done_q, frame_done_d;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [31:0]   pix_data_q;
  logic          pix_valid_q;
  logic          ovf_q, unf_q;

  logic          flush_pend;
  logic          do_flush;
  logic          push_try;
  logic          push_ok;
  logic          pop_ok;
  logic          last_word;

  assign flush_pend = flush_pend_q | frame_start;
  assign do_flush   = (state_q == ST_FLUSH);
  // Once a flush is pending, the rest of the in-flight burst is counted but not stored.
  assign push_try   = rd_data_valid && !flush_pend_q && !do_flush;
  assign push_ok    = push_try && (level_q != DEPTH_L);
  assign pop_ok     = pix_rd_en && (level_q != '0) && !do_flush;
  assign last_word  = (state_q == ST_DATA) && rd_data_valid &&
                      (word_cnt_q == XFR_LEN - 10'd1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    req_d        = req_q;
    req_cnt_d    = req_cnt_q;
    word_cnt_d   = word_cnt_q;
    flush_pend_d = flush_pend_q | frame_start;
    frame_done_d = last_word && !flush_pend_q && (req_cnt_q == FRAME_XFRS - 16'd1);
    case (state_q)
      ST_IDLE: begin
        if (flush_pend)  state_d = ST_FLUSH;
        else if (enable) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (flush_pend)                     state_d = ST_FLUSH;
        else if (!enable)                   state_d = ST_IDLE;
        else if (req_cnt_q == FRAME_XFRS)   state_d = ST_HOLD;
        else if (level_q <= REQ_THRESH) begin
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rd_mem_grant) begin
          req_d      = 1'b0;
          word_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_word) begin
          word_cnt_d = '0;
          addr_d     = addr_q + ADDR_STEP;
          req_cnt_d  = req_cnt_q + 16'd1;
          state_d    = ST_CHECK;
        end else if (rd_data_valid) begin
          word_cnt_d = word_cnt_q + 10'd1;
        end
      end
      ST_FLUSH: begin
        addr_d       = BASE_ADDR;
        req_cnt_d    = '0;
        flush_pend_d = frame_start;
        state_d      = ST_CHECK;
      end
      ST_HOLD: begin
        if (flush_pend) state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= BASE_ADDR;
      req_q        <= 1'b0;
      req_cnt_q    <= '0;
      word_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      req_cnt_q    <= req_cnt_d;
      word_cnt_q   <= word_cnt_d;
      flush_pend_q <= flush_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk0) begin
    if (push_ok) mem[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (do_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
      end
      pix_valid_q <= pop_ok;
      if (pop_ok) pix_data_q <= mem[rd_ptr_q];
      if (push_try && (level_q == DEPTH_L)) ovf_q <= 1'b1;
      if (pix_rd_en && (level_q == '0))     unf_q <= 1'b1;
    end
  end

  assign rd_mem_req  = req_q;
  assign rd_mem_addr = addr_q;
  assign rd_xfr_len  = XFR_LEN;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign pix_empty   = (level_q == '0);
  assign fifo_level  = level_q;
  assign frame_done  = frame_done_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule
